// File: rtl/rst_seq_if.sv
// rst_seq_if: debug run/step controls and the reset/enable outputs of the reset sequencer.
interface rst_seq_if;
    logic       RUN;
    logic       STEP;
    logic       DIV_RST;
    logic       MEM_RST;
    logic       CPU_RST;
    logic       MEM_EN;
    logic       CPU_EN;
    logic       HALTED;
    logic [2:0] STATE;
    modport master (output RUN, STEP, input DIV_RST, MEM_RST, CPU_RST, MEM_EN, CPU_EN, HALTED, STATE);
    modport slave  (input RUN, STEP, output DIV_RST, MEM_RST, CPU_RST, MEM_EN, CPU_EN, HALTED, STATE);
endinterface

// File: rtl/rst_seq.sv
// rst_seq: stretches reset for the clock divider, releases memory then CPU reset on phase
// boundaries, and emits phase-aligned MEM_EN/CPU_EN strobes with run/halt/step CPU gating.
module rst_seq #(
    parameter int HOLD_CYCLES  = 16,
    parameter int MEM_LEAD     = 4,
    parameter bit START_HALTED = 1'b0
) (
    input  logic     MASTER_CLK,
    input  logic     RESET,
    rst_seq_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int LW = $clog2(MEM_LEAD) + 1;
    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_MEM_WAKE = 3'd1,
        S_LEAD     = 3'd2,
        S_RUN      = 3'd3,
        S_HALT     = 3'd4,
        S_STEP     = 3'd5
    } state_t;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [LW-1:0] lead_cnt_q, lead_cnt_d, lead_inc;
    logic [1:0]    ph_q, ph_d;
    logic          div_rst_q, mem_rst_q, cpu_rst_q, halted_q;
    logic          mem_en, cpu_en;
    assign mem_en   = ph_q[0] & ~div_rst_q;
    assign cpu_en   = (ph_q == 2'd3) && (state_q == S_RUN || state_q == S_STEP);
    // the strobe landing in LEAD's exit cycle counts toward the lead
    assign lead_inc = (mem_en && lead_cnt_q != '1) ? lead_cnt_q + LW'(1) : lead_cnt_q;
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lead_cnt_d = lead_cnt_q;
        ph_d       = div_rst_q ? 2'd0 : ph_q + 2'd1;
        if (RESET) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            lead_cnt_d = '0;
            ph_d       = 2'd0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + HW'(hold_cnt_q != '1);
                    state_d    = (hold_cnt_q == HW'(HOLD_CYCLES - 1)) ? S_MEM_WAKE : S_HOLD;
                end
                S_MEM_WAKE: state_d = (ph_q == 2'd3) ? S_LEAD : S_MEM_WAKE;
                S_LEAD: begin
                    lead_cnt_d = lead_inc;
                    if (ph_q == 2'd3 && lead_inc >= LW'(MEM_LEAD))
                        state_d = START_HALTED ? S_HALT : S_RUN;
                end
                S_RUN:  state_d = bus.RUN ? S_RUN : S_HALT;
                S_HALT: state_d = bus.RUN ? S_RUN : (bus.STEP ? S_STEP : S_HALT);
                S_STEP: state_d = (ph_q == 2'd3) ? S_HALT : S_STEP;
                default: state_d = S_HOLD;
            endcase
        end
    end
    always_ff @(posedge MASTER_CLK) begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        lead_cnt_q <= lead_cnt_d;
        ph_q       <= ph_d;
        div_rst_q  <= state_d == S_HOLD;
        mem_rst_q  <= state_d == S_HOLD || state_d == S_MEM_WAKE;
        cpu_rst_q  <= state_d == S_HOLD || state_d == S_MEM_WAKE || state_d == S_LEAD;
        halted_q   <= state_d == S_HALT || state_d == S_STEP;
    end
    assign bus.DIV_RST = div_rst_q;
    assign bus.MEM_RST = mem_rst_q;
    assign bus.CPU_RST = cpu_rst_q;
    assign bus.MEM_EN  = mem_en;
    assign bus.CPU_EN  = cpu_en;
    assign bus.HALTED  = halted_q;
    assign bus.STATE   = state_q;
endmodule
